// File: rtl/alu_pkg.sv
// Shared definitions for the ALU shift stage: the op-select encoding
// carried on in_sel and used by the shifter.
package alu_pkg;

    typedef enum logic [1:0] {
        SH_SHL = 2'b00,
        SH_SHR = 2'b01,
        SH_ROL = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

endpackage

// File: rtl/alu_shift_stage_if.sv
// Request/response bundle for alu_shift_stage; the bench drives the master side,
// the stage sits on the slave side.
interface alu_shift_stage_if #(
    parameter int width     = 8,
    parameter int cnt_width = 3
);
    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // sender holds its payload steady until then, and ready may depend on valid.
    logic                 in_valid;
    logic                 in_ready;
    logic [width-1:0]     in_a;
    logic [cnt_width-1:0] in_cnt;
    logic [1:0]           in_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [width-1:0]     out_res;
    logic                 out_co;
    logic                 out_z;
    logic                 out_n;

    modport master (
        output in_valid, in_a, in_cnt, in_sel, out_ready,
        input  in_ready, out_valid, out_res, out_co, out_z, out_n
    );

    modport slave (
        input  in_valid, in_a, in_cnt, in_sel, out_ready,
        output in_ready, out_valid, out_res, out_co, out_z, out_n
    );
endinterface

// File: rtl/ALU_Shift.sv
// Combinational shifter/rotator placed between the two pipeline stages;
// produces the result and the carry for all four ops.
module ALU_Shift
    import alu_pkg::*;
#(
    parameter int width     = 8,
    parameter int cnt_width = 3
) (
    input  logic [width-1:0]     a,
    input  logic [cnt_width-1:0] cnt,
    input  sh_op_e               sel,
    output logic [width-1:0]     res,
    output logic                 co
);

    logic [width:0]       shl_w;
    logic [width:0]       shr_w;
    logic [width-1:0]     rol_w;
    logic [width-1:0]     ror_w;
    logic [cnt_width-1:0] l_idx;
    logic [cnt_width-1:0] r_idx;

    always_comb begin
        // The extra bit catches the last bit shifted out, which is the carry.
        shl_w = {1'b0, a} << cnt;
        shr_w = {a, 1'b0} >> cnt;
        rol_w = '0;
        ror_w = '0;
        l_idx = '0;
        r_idx = '0;
        // width == 2**cnt_width, so index arithmetic wraps modulo width for free.
        for (int i = 0; i < width; i++) begin
            l_idx    = cnt_width'(i) - cnt;
            r_idx    = cnt_width'(i) + cnt;
            rol_w[i] = a[l_idx];
            ror_w[i] = a[r_idx];
        end
        res = '0;
        co  = 1'b0;
        case (sel)
            SH_SHL: begin
                res = shl_w[width-1:0];
                co  = shl_w[width];
            end
            SH_SHR: begin
                res = shr_w[width:1];
                co  = shr_w[0];
            end
            SH_ROL: begin
                res = rol_w;
                co  = rol_w[0];
            end
            SH_ROR: begin
                res = ror_w;
                co  = ror_w[width-1];
            end
            default: begin
                res = '0;
                co  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_shift_stage.sv
// Two-stage shift/rotate pipeline with valid/ready on both sides.
// Define ALU_SHIFT_STAGE_FLAGS_EN to compute and register the zero/negative flags.
module alu_shift_stage
    import alu_pkg::*;
#(
    parameter int width     = 8,
    parameter int cnt_width = 3
) (
    input  logic             clk,
    input  logic             rst,
    alu_shift_stage_if.slave io
);

    logic                 s1_valid_q, s1_valid_d;
    logic [width-1:0]     s1_a_q, s1_a_d;
    logic [cnt_width-1:0] s1_cnt_q, s1_cnt_d;
    sh_op_e               s1_sel_q, s1_sel_d;
    logic                 out_valid_q, out_valid_d;
    logic [width-1:0]     out_res_q, out_res_d;
    logic                 out_co_q, out_co_d;

    logic                 advance;
    logic                 in_ready_w;
    logic                 accept;
    logic                 load_res;
    logic [width-1:0]     sh_res;
    logic                 sh_co;

    ALU_Shift #(
        .width     (width),
        .cnt_width (cnt_width)
    ) u_shift (
        .a   (s1_a_q),
        .cnt (s1_cnt_q),
        .sel (s1_sel_q),
        .res (sh_res),
        .co  (sh_co)
    );

    always_comb begin
        // Stage 2 frees up when empty or being popped; stage 1 moves under the same condition.
        advance    = !out_valid_q || io.out_ready;
        in_ready_w = !rst && (!s1_valid_q || advance);
        accept     = io.in_valid && in_ready_w;
        load_res   = advance && s1_valid_q;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_cnt_d   = s1_cnt_q;
        s1_sel_d   = s1_sel_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = io.in_a;
            s1_cnt_d   = io.in_cnt;
            s1_sel_d   = sh_op_e'(io.in_sel);
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_co_d    = out_co_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
        end
        if (load_res) begin
            out_res_d = sh_res;
            out_co_d  = sh_co;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_cnt_q    <= '0;
            s1_sel_q    <= SH_SHL;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_co_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_cnt_q    <= s1_cnt_d;
            s1_sel_q    <= s1_sel_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_co_q    <= out_co_d;
        end
    end

`ifdef ALU_SHIFT_STAGE_FLAGS_EN
    logic out_z_q, out_z_d;
    logic out_n_q, out_n_d;

    always_comb begin
        out_z_d = out_z_q;
        out_n_d = out_n_q;
        if (load_res) begin
            out_z_d = (sh_res == '0);
            out_n_d = sh_res[width-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_z_q <= 1'b0;
            out_n_q <= 1'b0;
        end else begin
            out_z_q <= out_z_d;
            out_n_q <= out_n_d;
        end
    end

    assign io.out_z = out_z_q;
    assign io.out_n = out_n_q;
`else
    assign io.out_z = 1'b0;
    assign io.out_n = 1'b0;
`endif

    assign io.in_ready  = in_ready_w;
    assign io.out_valid = out_valid_q;
    assign io.out_res   = out_res_q;
    assign io.out_co    = out_co_q;

endmodule
